// File: rtl/video_timing_gen.sv
// Raster timing generator: HSYNC/VSYNC/DE plus pixel/line counters, with
// optional frame-lock of the output raster to an asynchronous source VSYNC.
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter bit VSI_POL     = 1'b0,
  parameter int CNT_W       = 11,
  parameter bit LOCK_EN     = 1'b1,
  parameter int LOCK_VLINE  = 490,
  parameter int LOCK_FRAMES = 4
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             VSYNC_in,
  output logic             HSYNC_out,
  output logic             VSYNC_out,
  output logic             DE_out,
  output logic [CNT_W-1:0] H_cnt,
  output logic [CNT_W-1:0] V_cnt,
  output logic             frame_start,
  output logic             locked
);

  localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int TMO_LINES = 2 * V_TOTAL;
  localparam int TMO_W     = $clog2(TMO_LINES + 1);
  localparam int STB_W     = $clog2(LOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] LOCK_V   = CNT_W'(LOCK_VLINE);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_LINES);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_FRAMES);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [2:0]       vsi_q;
  logic             pending_q, pending_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             locked_d;

  logic             hsync_q, vsync_q, de_q, fs_q, locked_q;
  logic [CNT_W-1:0] hcnt_q, vcnt_q;

  logic             line_end;
  logic             apply;
  logic             vsi_edge;
  logic [CNT_W-1:0] v_inc;

  // stages 0/1 synchronise, stage 2 is the history bit for edge detection
  assign vsi_edge = LOCK_EN && (vsi_q[1] == VSI_POL) && (vsi_q[2] != VSI_POL);
  assign line_end = (h_q == H_LAST);
  assign apply    = line_end && pending_q;
  assign v_inc    = (v_q == V_LAST) ? '0 : v_q + 1'b1;

  always_comb begin
    h_d       = line_end ? '0 : h_q + 1'b1;
    v_d       = v_q;
    pending_d = pending_q;
    stable_d  = stable_q;
    tmo_d     = tmo_q;

    if (line_end) begin
      v_d = apply ? LOCK_V : v_inc;
    end

    // an edge arriving while a lock is already queued is absorbed
    if (apply) begin
      pending_d = 1'b0;
    end else if (vsi_edge) begin
      pending_d = 1'b1;
    end

    if (vsi_edge) begin
      tmo_d = '0;
    end else if (line_end && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + 1'b1;
    end

    // a lock that lands where the raster was going anyway counts as stable
    if (tmo_d == TMO_MAX) begin
      stable_d = '0;
    end else if (apply) begin
      if (v_inc == LOCK_V) begin
        if (stable_q != STB_MAX) begin
          stable_d = stable_q + 1'b1;
        end
      end else begin
        stable_d = '0;
      end
    end

    locked_d = LOCK_EN && (stable_d == STB_MAX);
  end

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      h_q       <= '0;
      v_q       <= '0;
      vsi_q     <= {3{~VSI_POL}};
      pending_q <= 1'b0;
      stable_q  <= '0;
      tmo_q     <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      vsi_q     <= {vsi_q[1:0], VSYNC_in};
      pending_q <= pending_d;
      stable_q  <= stable_d;
      tmo_q     <= tmo_d;
      hsync_q   <= ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync_q   <= ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VS_POL : ~VS_POL;
      de_q      <= (h_q < H_ACT) && (v_q < V_ACT);
      hcnt_q    <= h_q;
      vcnt_q    <= v_q;
      fs_q      <= (h_q == '0) && (v_q == '0);
      locked_q  <= locked_d;
    end
  end

  assign HSYNC_out   = hsync_q;
  assign VSYNC_out   = vsync_q;
  assign DE_out      = de_q;
  assign H_cnt       = hcnt_q;
  assign V_cnt       = vcnt_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;

endmodule
